// File: rtl/stream_rsp_router_pkg.sv
// Shared parameter defaults and width helpers for the stream response router.
package stream_rsp_router_pkg;

    localparam int unsigned DEF_NUM_REQS    = 4;
    localparam int unsigned DEF_DATAW       = 32;
    localparam int unsigned DEF_RSP_DATAW   = 32;
    localparam int unsigned DEF_MAX_PENDING = 8;

    // Select index width; a single requester still needs one bit.
    function automatic int unsigned sel_width(input int unsigned num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/stream_rsp_router_if.sv
// Request and response handshake bundle between the arbiter, the router and the target.
interface stream_rsp_router_if
    import stream_rsp_router_pkg::*;
#(
    parameter int unsigned NUM_REQS  = DEF_NUM_REQS,
    parameter int unsigned DATAW     = DEF_DATAW,
    parameter int unsigned RSP_DATAW = DEF_RSP_DATAW,
    parameter int unsigned SEL_W     = sel_width(NUM_REQS)
);

    logic                                req_valid_in;
    logic [DATAW-1:0]                    req_data_in;
    logic [SEL_W-1:0]                    req_sel_in;
    logic                                req_ready_in;
    logic                                req_valid_out;
    logic [DATAW-1:0]                    req_data_out;
    logic                                req_ready_out;
    logic                                rsp_valid_in;
    logic [RSP_DATAW-1:0]                rsp_data_in;
    logic                                rsp_ready_in;
    logic [NUM_REQS-1:0]                 rsp_valid_out;
    logic [NUM_REQS-1:0][RSP_DATAW-1:0]  rsp_data_out;
    logic [NUM_REQS-1:0]                 rsp_ready_out;

    modport slave (
        input  req_valid_in,
        input  req_data_in,
        input  req_sel_in,
        output req_ready_in,
        output req_valid_out,
        output req_data_out,
        input  req_ready_out,
        input  rsp_valid_in,
        input  rsp_data_in,
        output rsp_ready_in,
        output rsp_valid_out,
        output rsp_data_out,
        input  rsp_ready_out
    );

    modport master (
        output req_valid_in,
        output req_data_in,
        output req_sel_in,
        input  req_ready_in,
        input  req_valid_out,
        input  req_data_out,
        output req_ready_out,
        output rsp_valid_in,
        output rsp_data_in,
        input  rsp_ready_in,
        input  rsp_valid_out,
        input  rsp_data_out,
        output rsp_ready_out
    );

endinterface

// File: rtl/stream_rsp_tag_fifo.sv
// In-order tag FIFO: circular flop storage with naturally wrapping pointers.
module stream_rsp_tag_fifo #(
    parameter int unsigned DATAW = 2,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign data_out = r_mem[r_rd_ptr];
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/stream_rsp_router.sv
// Forwards arbitrated requests to a shared in-order target and steers each response
// back to the requester whose select index sits at the head of the tag FIFO.
module stream_rsp_router
    import stream_rsp_router_pkg::*;
#(
    parameter int unsigned NUM_REQS    = DEF_NUM_REQS,
    parameter int unsigned DATAW       = DEF_DATAW,
    parameter int unsigned RSP_DATAW   = DEF_RSP_DATAW,
    parameter int unsigned MAX_PENDING = DEF_MAX_PENDING,
    localparam int unsigned SEL_W      = sel_width(NUM_REQS),
    localparam int unsigned CNT_W      = cnt_width(MAX_PENDING)
) (
    input  logic                 clk,
    input  logic                 reset,
    stream_rsp_router_if.slave   bus,
    output logic [CNT_W-1:0]     pending,
    output logic                 idle
);

    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic [SEL_W-1:0]     w_head_sel;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_out_free;
    logic                 w_out_drain;

    logic                 r_out_valid;
    logic [SEL_W-1:0]     r_out_sel;
    logic [RSP_DATAW-1:0] r_out_data;

    // Full gates requests even if a pop lands this cycle, so req_ready_in never
    // depends combinationally on the response side.
    assign bus.req_valid_out = bus.req_valid_in & ~w_full;
    assign bus.req_ready_in  = bus.req_ready_out & ~w_full;
    assign bus.req_data_out  = bus.req_data_in;
    assign w_push            = bus.req_valid_in & bus.req_ready_in;

    assign w_out_drain      = r_out_valid & bus.rsp_ready_out[r_out_sel];
    assign w_out_free       = ~r_out_valid | bus.rsp_ready_out[r_out_sel];
    assign bus.rsp_ready_in = ~w_empty & w_out_free;
    assign w_pop            = bus.rsp_valid_in & bus.rsp_ready_in;

    stream_rsp_tag_fifo #(
        .DATAW (SEL_W),
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .data_in  (bus.req_sel_in),
        .data_out (w_head_sel),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_out_data  <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_sel   <= w_head_sel;
            r_out_data  <= bus.rsp_data_in;
        end else if (w_out_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    always_comb begin
        bus.rsp_valid_out = '0;
        bus.rsp_data_out  = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            bus.rsp_valid_out[i] = r_out_valid && (r_out_sel == SEL_W'(i));
            bus.rsp_data_out[i]  = r_out_data;
        end
    end

    assign pending = w_count;
    assign idle    = (w_count == '0) & ~r_out_valid;

    // A response with nothing outstanding means the target and router disagree.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(bus.rsp_valid_in && w_empty))
        else $error("stream_rsp_router: response with no pending request");

endmodule

// File: tb/tb_stream_rsp_router.sv
// Directed bench for stream_rsp_router with a queue-based reference model checked every cycle.
module tb_stream_rsp_router;

    localparam int unsigned NREQ = 4;
    localparam int unsigned MAXP = 8;

    logic       clk;
    logic       reset;
    logic [3:0] pending;
    logic       idle;

    int n_cmp = 0;
    int n_err = 0;

    stream_rsp_router_if #(.NUM_REQS(NREQ), .DATAW(32), .RSP_DATAW(32)) bus ();

    stream_rsp_router #(
        .NUM_REQS    (NREQ),
        .DATAW       (32),
        .RSP_DATAW   (32),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pending (pending),
        .idle    (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference model: outstanding tags in order, plus the single held response.
    int          m_tags[$];
    bit          m_hv;
    int          m_hs;
    logic [31:0] m_hd;

    always @(negedge clk) begin
        bit          full;
        bit          exp_req_rdy;
        bit          exp_rsp_rdy;
        logic [3:0]  exp_lanes;
        if (reset) begin
            m_tags.delete();
            m_hv = 1'b0;
            m_hs = 0;
        end
        full        = (m_tags.size() == MAXP);
        exp_req_rdy = bus.req_ready_out && !full;
        exp_rsp_rdy = (m_tags.size() > 0) && (!m_hv || bus.rsp_ready_out[m_hs]);
        exp_lanes   = m_hv ? (4'b0001 << m_hs) : 4'b0000;
        check("model req_ready_in", 64'(bus.req_ready_in), 64'(exp_req_rdy));
        check("model req_valid_out", 64'(bus.req_valid_out), 64'(bus.req_valid_in && !full));
        check("model req_data_out", 64'(bus.req_data_out), 64'(bus.req_data_in));
        check("model rsp_ready_in", 64'(bus.rsp_ready_in), 64'(exp_rsp_rdy));
        check("model rsp_valid_out", 64'(bus.rsp_valid_out), 64'(exp_lanes));
        check("model pending", 64'(pending), 64'(m_tags.size()));
        check("model idle", 64'(idle), 64'((m_tags.size() == 0) && !m_hv));
        if (m_hv) begin
            for (int i = 0; i < NREQ; i++) begin
                check("model rsp_data_out", 64'(bus.rsp_data_out[i]), 64'(m_hd));
            end
        end
        if (!reset) begin
            if (bus.rsp_valid_in && exp_rsp_rdy) begin
                m_hs = m_tags.pop_front();
                m_hv = 1'b1;
                m_hd = bus.rsp_data_in;
            end else if (m_hv && bus.rsp_ready_out[m_hs]) begin
                m_hv = 1'b0;
            end
            if (bus.req_valid_in && exp_req_rdy) begin
                m_tags.push_back(int'(bus.req_sel_in));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int         seq[4];
        logic [3:0] lane;
        seq = '{0, 3, 1, 3};

        reset             = 1'b1;
        bus.req_valid_in  = 1'b0;
        bus.req_data_in   = '0;
        bus.req_sel_in    = '0;
        bus.req_ready_out = 1'b1;
        bus.rsp_valid_in  = 1'b0;
        bus.rsp_data_in   = '0;
        bus.rsp_ready_out = 4'b1111;
        #2;
        check("reset rsp_valid_out", 64'(bus.rsp_valid_out), 64'h0);
        check("reset pending", 64'(pending), 64'h0);
        check("reset idle", 64'(idle), 64'h1);
        check("reset rsp_ready_in", 64'(bus.rsp_ready_in), 64'h0);
        check("reset req_valid_out", 64'(bus.req_valid_out), 64'h0);
        tick();
        tick();
        reset = 1'b0;

        // Single request to lane 2, response three cycles later.
        bus.req_valid_in = 1'b1;
        bus.req_sel_in   = 2'd2;
        bus.req_data_in  = 32'h1111_2222;
        settle();
        check("t1 req_valid_out", 64'(bus.req_valid_out), 64'h1);
        check("t1 req_ready_in", 64'(bus.req_ready_in), 64'h1);
        check("t1 req_data_out", 64'(bus.req_data_out), 64'h1111_2222);
        tick();
        bus.req_valid_in = 1'b0;
        settle();
        check("t1 pending after push", 64'(pending), 64'h1);
        tick();
        tick();
        bus.rsp_valid_in = 1'b1;
        bus.rsp_data_in  = 32'hA5A5_A5A5;
        tick();
        bus.rsp_valid_in = 1'b0;
        settle();
        check("t1 rsp_valid_out", 64'(bus.rsp_valid_out), 64'h4);
        check("t1 rsp_data lane2", 64'(bus.rsp_data_out[2]), 64'hA5A5_A5A5);
        check("t1 pending after pop", 64'(pending), 64'h0);
        tick();
        settle();
        check("t1 drained", 64'(bus.rsp_valid_out), 64'h0);
        check("t1 idle", 64'(idle), 64'h1);

        // Back-to-back requests, in-order responses on consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            bus.req_valid_in = 1'b1;
            bus.req_sel_in   = 2'(seq[k]);
            bus.req_data_in  = 32'(k);
            tick();
        end
        bus.req_valid_in = 1'b0;
        settle();
        check("t2 pending", 64'(pending), 64'h4);
        for (int k = 0; k < 4; k++) begin
            bus.rsp_valid_in = 1'b1;
            bus.rsp_data_in  = 32'hB000_0000 + 32'(k);
            tick();
            settle();
            lane = 4'b0001 << seq[k];
            check("t2 lane", 64'(bus.rsp_valid_out), 64'(lane));
            check("t2 data", 64'(bus.rsp_data_out[seq[k]]), 64'(32'hB000_0000 + 32'(k)));
        end
        bus.rsp_valid_in = 1'b0;
        tick();
        settle();
        check("t2 idle", 64'(idle), 64'h1);

        // Fill to MAX_PENDING; a same-cycle pop must not unblock the 9th request.
        for (int k = 0; k < 8; k++) begin
            bus.req_valid_in = 1'b1;
            bus.req_sel_in   = 2'(k % 4);
            bus.req_data_in  = 32'h100 + 32'(k);
            tick();
        end
        bus.req_sel_in   = 2'd1;
        bus.req_data_in  = 32'h109;
        bus.rsp_valid_in = 1'b1;
        bus.rsp_data_in  = 32'h0000_0900;
        settle();
        check("t3 full pending", 64'(pending), 64'h8);
        check("t3 full req_ready_in", 64'(bus.req_ready_in), 64'h0);
        check("t3 full req_valid_out", 64'(bus.req_valid_out), 64'h0);
        check("t3 full rsp_ready_in", 64'(bus.rsp_ready_in), 64'h1);
        tick();
        bus.rsp_valid_in = 1'b0;
        settle();
        check("t3 after pop pending", 64'(pending), 64'h7);
        check("t3 after pop req_ready_in", 64'(bus.req_ready_in), 64'h1);
        check("t3 after pop lane0", 64'(bus.rsp_valid_out), 64'h1);
        tick();
        bus.req_valid_in = 1'b0;
        settle();
        check("t3 refill pending", 64'(pending), 64'h8);
        for (int k = 0; k < 8; k++) begin
            bus.rsp_valid_in = 1'b1;
            bus.rsp_data_in  = 32'h0000_0A00 + 32'(k);
            tick();
        end
        bus.rsp_valid_in = 1'b0;
        settle();
        check("t3 last lane", 64'(bus.rsp_valid_out), 64'h2);
        tick();
        settle();
        check("t3 idle", 64'(idle), 64'h1);

        // Lane 1 stalls; output holds and the following response waits.
        bus.req_valid_in = 1'b1;
        bus.req_sel_in   = 2'd1;
        tick();
        bus.req_sel_in   = 2'd2;
        tick();
        bus.req_valid_in  = 1'b0;
        bus.rsp_ready_out = 4'b1101;
        bus.rsp_valid_in  = 1'b1;
        bus.rsp_data_in   = 32'h0000_00C1;
        tick();
        bus.rsp_data_in   = 32'h0000_00C2;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("t4 held lane", 64'(bus.rsp_valid_out), 64'h2);
            check("t4 held data", 64'(bus.rsp_data_out[1]), 64'hC1);
            check("t4 rsp_ready_in", 64'(bus.rsp_ready_in), 64'h0);
            check("t4 pending", 64'(pending), 64'h1);
            tick();
        end
        bus.rsp_ready_out = 4'b1111;
        settle();
        check("t4 release rsp_ready_in", 64'(bus.rsp_ready_in), 64'h1);
        tick();
        bus.rsp_valid_in = 1'b0;
        settle();
        check("t4 second lane", 64'(bus.rsp_valid_out), 64'h4);
        check("t4 second data", 64'(bus.rsp_data_out[2]), 64'hC2);
        tick();
        settle();
        check("t4 idle", 64'(idle), 64'h1);

        // Orphan response is refused; kept clear of the sampling edge.
        bus.rsp_valid_in = 1'b1;
        bus.rsp_data_in  = 32'hDEAD_BEEF;
        settle();
        check("t5 rsp_ready_in", 64'(bus.rsp_ready_in), 64'h0);
        check("t5 rsp_valid_out", 64'(bus.rsp_valid_out), 64'h0);
        bus.rsp_valid_in = 1'b0;
        tick();
        settle();
        check("t5 no output", 64'(bus.rsp_valid_out), 64'h0);
        check("t5 pending", 64'(pending), 64'h0);

        // Asynchronous reset with five tags and a held response.
        for (int k = 0; k < 6; k++) begin
            bus.req_valid_in = 1'b1;
            bus.req_sel_in   = 2'(k % 4);
            tick();
        end
        bus.req_valid_in  = 1'b0;
        bus.rsp_ready_out = 4'b1110;
        bus.rsp_valid_in  = 1'b1;
        bus.rsp_data_in   = 32'h0000_00D0;
        tick();
        bus.rsp_valid_in = 1'b0;
        settle();
        check("t6 pre pending", 64'(pending), 64'h5);
        check("t6 pre lane", 64'(bus.rsp_valid_out), 64'h1);
        reset = 1'b1;
        settle();
        check("t6 reset rsp_valid_out", 64'(bus.rsp_valid_out), 64'h0);
        check("t6 reset pending", 64'(pending), 64'h0);
        check("t6 reset idle", 64'(idle), 64'h1);
        check("t6 reset rsp_ready_in", 64'(bus.rsp_ready_in), 64'h0);
        check("t6 reset req_valid_out", 64'(bus.req_valid_out), 64'h0);
        tick();
        tick();
        reset             = 1'b0;
        bus.rsp_ready_out = 4'b1111;
        bus.req_valid_in  = 1'b1;
        bus.req_sel_in    = 2'd3;
        tick();
        bus.req_valid_in = 1'b0;
        bus.rsp_valid_in = 1'b1;
        bus.rsp_data_in  = 32'h0000_E3E3;
        tick();
        bus.rsp_valid_in = 1'b0;
        settle();
        check("t6 post lane", 64'(bus.rsp_valid_out), 64'h8);
        check("t6 post data", 64'(bus.rsp_data_out[3]), 64'hE3E3);
        check("t6 post pending", 64'(pending), 64'h0);
        tick();
        settle();
        check("t6 post idle", 64'(idle), 64'h1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
